// File: rtl/dram_stream_pkg.sv
// Shared constants, state encoding and pixel-flag layout for the DRAM-to-pixel stream path.
package dram_stream_pkg;
    localparam int BURST     = 64;
    localparam int H_ACTIVE  = 1600;
    localparam int V_ACTIVE  = 900;
    localparam int FRAME     = H_ACTIVE * V_ACTIVE;

    localparam int RGB_W     = 24;
    localparam int X_W       = 11;
    localparam int Y_W       = 10;
    localparam int FLAG_W    = 3;
    localparam int IDX_W     = 21;
    localparam int TAG_W     = X_W + Y_W + FLAG_W;
    localparam int PAYLOAD_W = RGB_W + TAG_W;

    localparam int FLAG_SOF  = 0;
    localparam int FLAG_EOL  = 1;
    localparam int FLAG_EOF  = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_WAIT = 3'd2,
        S_STREAM    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    function automatic logic [FLAG_W-1:0] pix_flags_of(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int             h,
        input int             v
    );
        logic [FLAG_W-1:0] f;
        f           = '0;
        f[FLAG_SOF] = (x == '0) && (y == '0);
        f[FLAG_EOL] = (int'(x) == h - 1);
        f[FLAG_EOF] = (int'(x) == h - 1) && (int'(y) == v - 1);
        return f;
    endfunction
endpackage

// File: rtl/rgb_fifo2stream_if.sv
// Pixel stream bundle: valid/ready handshake plus RGB data and its raster tags.
interface rgb_fifo2stream_if;
    import dram_stream_pkg::*;

    logic              pix_valid;
    logic              pix_ready;
    logic [RGB_W-1:0]  pix_data;
    logic [X_W-1:0]    pix_x;
    logic [Y_W-1:0]    pix_y;
    logic [FLAG_W-1:0] pix_flags;

    modport master (output pix_valid, pix_data, pix_x, pix_y, pix_flags, input pix_ready);
    modport slave  (input pix_valid, pix_data, pix_x, pix_y, pix_flags, output pix_ready);
endinterface

// File: rtl/rgb_fifo2stream_pix_skid2.sv
// Two-entry output buffer; the head entry drives the outputs and only moves on acceptance.
module pix_skid2 import dram_stream_pkg::*; #(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= in_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        tail  <= in_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/rgb_fifo2stream.sv
// Pops DRAM read bursts out of the RGB FIFO and emits them as a raster-tagged pixel stream.
module rgb_fifo2stream import dram_stream_pkg::*; #(
    parameter int BURST    = dram_stream_pkg::BURST,
    parameter int H_ACTIVE = dram_stream_pkg::H_ACTIVE,
    parameter int V_ACTIVE = dram_stream_pkg::V_ACTIVE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] rgb_cnt,
    output logic        rgb_rd,
    input  logic [31:0] rgb_in,
    output logic        addr_rd,
    input  logic [31:0] addr_in,
    input  logic        restart,
    rgb_fifo2stream_if.master pix,
    output logic        busy,
    output logic        seq_err
);
    localparam int                FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int                CNT_W     = $clog2(BURST + 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_ACTIVE - 1);
    localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0]  BURST_N   = CNT_W'(BURST);
    localparam logic [10:0]       CNT_THR   = 11'(BURST);

    state_t             state;
    state_t             state_nxt;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [IDX_W-1:0]   exp_idx;
    logic [CNT_W-1:0]   pop_left;
    logic [CNT_W-1:0]   acc_left;
    logic               vld_p1;
    logic [TAG_W-1:0]   tag_p1;
    logic [1:0]         occ;
    logic [2:0]         pending;
    logic               buf_valid;
    logic               accept;
    logic               load_burst;
    logic               restart_clr;
    logic               seq_mismatch;
    logic [PAYLOAD_W-1:0] buf_out;
    logic               buf_ready_unused;
    logic               unused_rgb_hi;

    assign unused_rgb_hi = ^rgb_in[31:24];
    assign accept        = buf_valid && pix.pix_ready;
    assign busy          = (state != S_IDLE);
    assign seq_mismatch  = (addr_in != {{(32-IDX_W){1'b0}}, exp_idx});
    // Count what will still be held after this cycle's accept, so a steady stream pops every cycle.
    assign pending       = {1'b0, occ} - {2'b0, accept} + {2'b0, vld_p1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rgb_rd      = 1'b0;
        addr_rd     = 1'b0;
        load_burst  = 1'b0;
        restart_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (rgb_cnt >= CNT_THR) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                addr_rd   = 1'b1;
                state_nxt = S_ADDR_WAIT;
            end
            S_ADDR_WAIT: begin
                load_burst = 1'b1;
                state_nxt  = S_STREAM;
            end
            S_STREAM: begin
                rgb_rd = (pop_left != '0) && (pending < 3'd2);
                // Leave only on the final accept, so nothing is stranded in the buffer.
                if (accept && acc_left == CNT_W'(1)) begin
                    state_nxt = (exp_idx == IDX_END) ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (restart) begin
                    restart_clr = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: raster position is assigned at pop time and travels with the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            exp_idx  <= '0;
            pop_left <= '0;
            acc_left <= '0;
            seq_err  <= 1'b0;
            vld_p1   <= 1'b0;
            tag_p1   <= '0;
        end else begin
            vld_p1 <= rgb_rd;
            if (load_burst) begin
                pop_left <= BURST_N;
                acc_left <= BURST_N;
                if (seq_mismatch) seq_err <= 1'b1;
            end
            if (restart_clr) begin
                x       <= '0;
                y       <= '0;
                exp_idx <= '0;
            end
            if (rgb_rd) begin
                tag_p1   <= {x, y, pix_flags_of(x, y, H_ACTIVE, V_ACTIVE)};
                pop_left <= pop_left - 1'b1;
                exp_idx  <= exp_idx + 1'b1;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (accept && acc_left != '0) acc_left <= acc_left - 1'b1;
        end
    end

    // Stage p1 -> buffer: FIFO data arrives one cycle after the strobe and joins its tag.
    pix_skid2 #(.W(PAYLOAD_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p1),
        .in_ready  (buf_ready_unused),
        .in_data   ({rgb_in[RGB_W-1:0], tag_p1}),
        .out_valid (buf_valid),
        .out_ready (pix.pix_ready),
        .out_data  (buf_out),
        .count     (occ)
    );

    assign pix.pix_valid = buf_valid;
    assign pix.pix_data  = buf_out[PAYLOAD_W-1 -: RGB_W];
    assign pix.pix_x     = buf_out[TAG_W-1 -: X_W];
    assign pix.pix_y     = buf_out[FLAG_W+Y_W-1 -: Y_W];
    assign pix.pix_flags = buf_out[FLAG_W-1:0];
endmodule

// File: tb/tb_rgb_fifo2stream.sv
// Randomized bench: FIFO/offset models feed the block, a raster scoreboard checks every accepted pixel.
module tb_rgb_fifo2stream;
    localparam int BURST = 64;
    localparam int H     = 1600;
    localparam int V     = 2;
    localparam int FRAME = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic [10:0] rgb_cnt = '0;
    logic        rgb_rd;
    logic [31:0] rgb_in = '0;
    logic        addr_rd;
    logic [31:0] addr_in = '0;
    logic        busy;
    logic        seq_err;

    rgb_fifo2stream_if pix();

    rgb_fifo2stream #(.BURST(BURST), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk     (clk),
        .rst     (rst),
        .rgb_cnt (rgb_cnt),
        .rgb_rd  (rgb_rd),
        .rgb_in  (rgb_in),
        .addr_rd (addr_rd),
        .addr_in (addr_in),
        .restart (restart),
        .pix     (pix),
        .busy    (busy),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream FIFOs in standard read mode: data appears the cycle after the strobe.
    logic [31:0] rgb_q[$];
    logic [31:0] addr_q[$];

    always begin
        logic rd_s, ard_s, rst_s;
        @(negedge clk);
        rd_s  = rgb_rd;
        ard_s = addr_rd;
        rst_s = rst;
        @(posedge clk);
        #1;
        if (rst_s) begin
            rgb_q.delete();
            addr_q.delete();
            rgb_in  = '0;
            addr_in = '0;
        end else begin
            if (rd_s) begin
                if (rgb_q.size() == 0) chk("rgb pop from empty fifo", 1, 0);
                else rgb_in = rgb_q.pop_front();
            end
            if (ard_s) begin
                if (addr_q.size() == 0) chk("offset pop from empty fifo", 1, 0);
                else addr_in = addr_q.pop_front();
            end
        end
        rgb_cnt = 11'(rgb_q.size());
    end

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix.pix_ready = 1'b1;
            1:       pix.pix_ready = ~pix.pix_ready;
            default: pix.pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: pixel n of the frame sits at (n % H, n / H).
    logic [47:0] exp_q[$];
    int  pos = 0;
    bit  exp_seq = 1'b0;
    int  cyc = 0;
    int  pops = 0, accs = 0, addr_pops = 0;
    int  first_rd = -1, first_vld = -1, last_acc = -1, burst_accs = 0;
    logic [47:0] first_pix = '0, last_pix = '0, hold_pix = '0;
    bit  stall = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [47:0] cur;
        cur = {pix.pix_data, pix.pix_x, pix.pix_y, pix.pix_flags};
        if (rst) begin
            stall = 1'b0;
            pops  = 0;
            accs  = 0;
        end else begin
            chk("buffer occupancy <= 2", 64'((pops - accs) <= 2), 1);
            if (stall) begin
                chk("stalled valid held", pix.pix_valid, 1);
                chk("stalled outputs held", cur, hold_pix);
            end
            if (rgb_rd) begin
                pops++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (addr_rd) addr_pops++;
            if (pix.pix_valid && first_vld < 0) first_vld = cyc;
            if (pix.pix_valid && pix.pix_ready) begin
                if (exp_q.size() == 0) chk("pixel with nothing expected", 1, 0);
                else chk("pixel {data,x,y,flags}", cur, exp_q.pop_front());
                if (burst_accs == 0) first_pix = cur;
                last_pix = cur;
                last_acc = cyc;
                burst_accs++;
                accs++;
            end
            stall    = pix.pix_valid && !pix.pix_ready;
            hold_pix = cur;
        end
    end

    task automatic load_burst(input int offset);
        for (int k = 0; k < BURST; k++) begin
            logic [31:0] w;
            logic [2:0]  f;
            int          idx;
            w   = $urandom;
            idx = pos + k;
            f   = {idx == FRAME - 1, (idx % H) == H - 1, idx == 0};
            rgb_q.push_back(w);
            exp_q.push_back({w[23:0], 11'(idx % H), 10'(idx / H), f});
        end
        addr_q.push_back(32'(offset));
        if (offset != pos) exp_seq = 1'b1;
        pos       += BURST;
        first_rd   = -1;
        first_vld  = -1;
        burst_accs = 0;
        rgb_cnt    = 11'(rgb_q.size());
    endtask

    task automatic wait_burst(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rgb_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, " finished in time"}, 64'(n < 5000), 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " seq_err"}, seq_err, exp_seq);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset pix_valid", pix.pix_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset seq_err", seq_err, 0);
        chk("reset rgb_rd", rgb_rd, 0);
        chk("reset addr_rd", addr_rd, 0);
        chk("reset pix outputs", {pix.pix_data, pix.pix_x, pix.pix_y, pix.pix_flags}, 0);
        exp_q.delete();
        pos     = 0;
        exp_seq = 1'b0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int n, p0, a0;
        pix.pix_ready = 1'b1;
        do_reset();

        // Single burst at offset 0, ready held high
        ready_mode = 0;
        load_burst(0);
        wait_burst("single");
        chk("first valid latency", 64'(first_vld - first_rd), 2);
        chk("one pixel per cycle", 64'(last_acc - first_vld), BURST - 1);
        chk("single first flags", first_pix[2:0], 3'b001);
        chk("single last x", first_pix[23:13] + 11'(BURST - 1), last_pix[23:13]);

        // Line wrap across x = H-1
        ready_mode = 2;
        for (int off = BURST; off <= 1600; off += BURST) begin
            load_burst(off);
            wait_burst("line");
            if (off == 1536) begin
                chk("wrap last x", last_pix[23:13], 1599);
                chk("wrap last y", last_pix[12:3], 0);
                chk("wrap last flags", last_pix[2:0], 3'b010);
            end
            if (off == 1600) chk("wrap next x,y", first_pix[23:3], {11'd0, 10'd1});
        end

        // Backpressure, with an out-of-state restart that must be ignored
        ready_mode = 1;
        for (int b = 0; b < 3; b++) begin
            load_burst(pos);
            if (b == 0) begin
                repeat (20) @(posedge clk);
                #1 restart = 1'b1;
                @(posedge clk);
                #1 restart = 1'b0;
            end
            wait_burst("backpressure");
        end

        // Wrong offset: seq_err sets, is sticky and the stream carries on
        ready_mode = 2;
        load_burst(pos + BURST);
        wait_burst("bad offset");
        load_burst(pos);
        wait_burst("after bad offset");
        chk("seq_err sticky", seq_err, 1);

        // Reset in the middle of a burst
        load_burst(pos);
        n = 0;
        while (burst_accs < 30 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid-burst reached 30 pixels", 64'(burst_accs >= 30), 1);
        do_reset();
        load_burst(0);
        wait_burst("after reset");
        chk("after reset first x,y", first_pix[23:3], 0);
        chk("after reset first flags", first_pix[2:0], 3'b001);

        // Full frame, then S_DONE, then restart
        do_reset();
        for (int b = 0; b < FRAME / BURST; b++) begin
            load_burst(b * BURST);
            wait_burst("frame");
        end
        chk("frame last x", last_pix[23:13], H - 1);
        chk("frame last y", last_pix[12:3], V - 1);
        chk("frame last flags", last_pix[2:0], 3'b110);
        chk("done busy", busy, 1);
        p0  = pops;
        a0  = addr_pops;
        pos = 0;
        load_burst(0);
        repeat (20) @(posedge clk);
        #1;
        chk("done no rgb reads", 64'(pops), 64'(p0));
        chk("done no offset reads", 64'(addr_pops), 64'(a0));
        chk("done no pixels", pix.pix_valid, 0);
        chk("done still busy", busy, 1);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        wait_burst("restart");
        chk("restart first x,y", first_pix[23:3], 0);
        chk("restart first flags", first_pix[2:0], 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rgb_fifo2stream.md
RGB_FIFO2STREAM -- requirements
Module: rgb_fifo2stream

Interface
REQ-001 Parameter BURST, default 64: words per DRAM read burst; the word count per offset entry.
REQ-002 Parameter H_ACTIVE, default 1600: pixels per line.
REQ-003 Parameter V_ACTIVE, default 900: lines per frame; frame = H_ACTIVE*V_ACTIVE = 1440000 pixels.
REQ-004 clk  in  1  single clock for all logic; same clock as the upstream FIFO read side.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rgb_cnt  in  11  upstream RGB FIFO read data count.
REQ-007 rgb_rd  out  1  RGB FIFO read strobe; standard mode, data valid on rgb_in the cycle after the strobe.
REQ-008 rgb_in  in  32  RGB FIFO data; bits [23:0] = {R,G,B}; bits [31:24] ignored.
REQ-009 addr_rd  out  1  offset FIFO read strobe; same 1-cycle latency.
REQ-010 addr_in  in  32  offset FIFO data: first pixel index of the burst.
REQ-011 restart  in  1  single-cycle pulse; re-arms the block after a frame completes.
REQ-012 pix_valid  out  1  output pixel valid.
REQ-013 pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready.
REQ-014 pix_data  out  24  RGB pixel.
REQ-015 pix_x  out  11  column, 0..H_ACTIVE-1.
REQ-016 pix_y  out  10  line, 0..V_ACTIVE-1.
REQ-017 pix_flags  out  3  {eof, eol, sof}: sof on pixel (0,0); eol on x=H_ACTIVE-1; eof on the last pixel of the frame.
REQ-018 busy  out  1  high in every state except S_IDLE.
REQ-019 seq_err  out  1  sticky; set when a popped offset differs from the expected pixel index.

Function
REQ-020 FSM states: S_IDLE, S_ADDR, S_ADDR_WAIT, S_STREAM, S_DONE.
REQ-021 S_IDLE -> S_ADDR when rgb_cnt >= BURST; a full burst is resident, so its offset entry is also present.
REQ-022 S_ADDR: assert addr_rd for exactly one cycle, then enter S_ADDR_WAIT.
REQ-023 S_ADDR_WAIT: compare addr_in with the 21-bit expected index exp_idx.
  - Mismatch: set seq_err.
  - Either way: load word counter with BURST and enter S_STREAM.
REQ-024 S_STREAM: rgb_rd asserted only when (buffered + in-flight words) < 2 and remaining-pop count > 0.
  - Exactly BURST pops per burst; never pop beyond BURST.
REQ-025 Output stage is a 2-entry buffer.
  - Popped words enter it the cycle after rgb_rd, tagged with x, y and flags.
  - pix_data, pix_x, pix_y and pix_flags are held stable while pix_valid && !pix_ready.
REQ-026 Latency: pix_valid rises 2 cycles after the first rgb_rd of a burst. With pix_ready held high, throughput is 1 pixel/cycle.
REQ-027 x/y counters advance when a word is popped, not when it is accepted.
  - x wraps H_ACTIVE-1 -> 0 and increments y.
  - exp_idx increments per pop.
REQ-028 Burst end, after BURST accepted pixels:
  - Frame not complete: go to S_IDLE.
  - exp_idx reached H_ACTIVE*V_ACTIVE: go to S_DONE.
REQ-029 The burst-end decision uses the accept count, so the FSM never leaves S_STREAM with pixels still buffered.
REQ-030 S_DONE: no pops.
  - restart clears x, y and exp_idx, then goes to S_IDLE.
  - restart in any other state is ignored.
REQ-031 rgb_cnt >= BURST while in S_DONE causes no reads.

Reset
REQ-032 rst has priority over all inputs. Next-cycle values: state S_IDLE; pix_valid=0; rgb_rd=0; addr_rd=0; busy=0; seq_err=0; x=y=exp_idx=0; buffer empty; pix_data, pix_x, pix_y, pix_flags all 0.
REQ-033 rst mid-burst discards buffered and in-flight words. The upstream FIFO reset, issued by the same rst, discards the remaining data.

Structure
REQ-034 BURST, H_ACTIVE, V_ACTIVE, frame size, FSM state encoding and the pix_flags bit indices live in shared package dram_stream_pkg.
REQ-035 The 2-entry output buffer is sub-module pix_skid2, carrying a 24+11+10+3 bit payload with valid/ready on both sides.

Verification
REQ-036 Single burst, offset 0, pix_ready=1:
  - 64 pixels at x=0..63, y=0.
  - sof only on the first pixel.
  - First pix_valid 2 cycles after the first rgb_rd.
REQ-037 Line wrap, offsets 1536 then 1600:
  - Pixel index 1599 has x=1599, y=0, eol=1.
  - Next pixel has x=0, y=1.
REQ-038 Backpressure, pix_ready toggled 1/0 every cycle:
  - Pixels are in order with no loss or duplication.
  - Outputs stable while stalled.
  - Buffer occupancy never exceeds 2.
REQ-039 Full frame, 22500 bursts:
  - Last pixel is x=1599, y=899 with flags 3'b110.
  - State S_DONE; no further rgb_rd.
  - restart followed by a new burst at offset 0 gives sof=1.
REQ-040 Offset 128 supplied where 64 is expected: seq_err rises and stays 1; the stream continues.
REQ-041 rst asserted after 30 of 64 pixels:
  - Next cycle: pix_valid=0, busy=0, seq_err=0.
  - After refill at offset 0, the first pixel has x=0, y=0 and sof=1.
